// File: rtl/writing_index_score.sv
// Score RAM write port for the NW datapath: optional gap init, then cell fill.
// Define WRITE_INIT_EN to write row 0 / column 0 from GAP in this block.
module writing_index_score #(
   parameter int N           = 128,
   parameter int BitAddr     = $clog2(N+1),
   parameter int addr_lenght = $clog2(((N+1)*(N+1))-1),
   parameter int SCORE_W     = 16,
   parameter int GAP         = -1
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic [SCORE_W-1:0] score_in,
   input  logic               score_valid,
   output logic               score_ready,
   output logic [BitAddr:0]   i,
   output logic [BitAddr:0]   j,
   output logic               wr_en,
   output logic [addr_lenght:0] wr_addr,
   output logic [SCORE_W-1:0] wr_data,
   output logic               busy,
   output logic               done
);

   localparam int IW = BitAddr + 1;
   localparam int AW = addr_lenght + 1;
   localparam logic [IW-1:0] LAST = IW'(N - 1);

   typedef enum logic [2:0] {
      IDLE, INIT_ROW, INIT_COL, FILL, DONE
   } state_t;

   state_t            state_q, state_d;
   logic [IW-1:0]     i_q, i_d, j_q, j_d;
   logic              rdy_q, rdy_d;
   logic              wr_q, wr_d;
   logic [AW-1:0]     addr_q, addr_d;
   logic [SCORE_W-1:0] data_q, data_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic              xfer;

`ifdef WRITE_INIT_EN
   logic [IW-1:0]     cnt_q, cnt_d;
`else
   localparam int unused_gap = GAP;
`endif

   assign xfer = score_valid & rdy_q;

   always_comb begin
      state_d = state_q;
      i_d     = i_q;
      j_d     = j_q;
      rdy_d   = rdy_q;
      wr_d    = 1'b0;
      addr_d  = addr_q;
      data_d  = data_q;
      done_d  = 1'b0;
`ifdef WRITE_INIT_EN
      cnt_d   = cnt_q;
`endif
      unique case (state_q)
         IDLE: begin
            if (start) begin
               i_d = '0;
               j_d = '0;
`ifdef WRITE_INIT_EN
               state_d = INIT_ROW;
               wr_d    = 1'b1;
               addr_d  = '0;
               data_d  = '0;
               cnt_d   = '0;
`else
               state_d = FILL;
               rdy_d   = 1'b1;
`endif
            end
         end
`ifdef WRITE_INIT_EN
         INIT_ROW: begin
            wr_d = 1'b1;
            if (cnt_q == IW'(N)) begin
               state_d = INIT_COL;
               cnt_d   = IW'(1);
               addr_d  = AW'(N + 1);
               data_d  = SCORE_W'(GAP);
            end else begin
               cnt_d  = cnt_q + IW'(1);
               addr_d = AW'(int'(cnt_q) + 1);
               data_d = SCORE_W'((int'(cnt_q) + 1) * GAP);
            end
         end
         INIT_COL: begin
            if (cnt_q == IW'(N)) begin
               state_d = FILL;
               rdy_d   = 1'b1;
            end else begin
               wr_d   = 1'b1;
               cnt_d  = cnt_q + IW'(1);
               addr_d = AW'((int'(cnt_q) + 1) * (N + 1));
               data_d = SCORE_W'((int'(cnt_q) + 1) * GAP);
            end
         end
`endif
         FILL: begin
            if (xfer) begin
               wr_d   = 1'b1;
               addr_d = AW'((int'(j_q) + 1) + (N + 1) * (int'(i_q) + 1));
               data_d = score_in;
               // last cell keeps i,j parked at N-1
               if (i_q == LAST && j_q == LAST) begin
                  state_d = DONE;
                  rdy_d   = 1'b0;
               end else if (j_q == LAST) begin
                  j_d = '0;
                  i_d = i_q + IW'(1);
               end else begin
                  j_d = j_q + IW'(1);
               end
            end
         end
         DONE: begin
            state_d = IDLE;
            done_d  = 1'b1;
         end
         default: state_d = IDLE;
      endcase
      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         i_q     <= '0;
         j_q     <= '0;
         rdy_q   <= 1'b0;
         wr_q    <= 1'b0;
         addr_q  <= '0;
         data_q  <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
`ifdef WRITE_INIT_EN
         cnt_q   <= '0;
`endif
      end else begin
         state_q <= state_d;
         i_q     <= i_d;
         j_q     <= j_d;
         rdy_q   <= rdy_d;
         wr_q    <= wr_d;
         addr_q  <= addr_d;
         data_q  <= data_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
`ifdef WRITE_INIT_EN
         cnt_q   <= cnt_d;
`endif
      end
   end

   assign score_ready = rdy_q;
   assign i           = i_q;
   assign j           = j_q;
   assign wr_en       = wr_q;
   assign wr_addr     = addr_q;
   assign wr_data     = data_q;
   assign busy        = busy_q;
   assign done        = done_q;

endmodule

// File: tb/tb_writing_index_score.sv
// Scoreboard bench for writing_index_score: random handshakes vs. a
// matrix-walk reference model; builds with or without WRITE_INIT_EN.
module tb_writing_index_score;

   localparam int N   = 4;
   localparam int SW  = 16;
   localparam int GAP = -1;
   localparam int IW  = $clog2(N+1) + 1;
   localparam int AW  = $clog2(((N+1)*(N+1))-1) + 1;

   logic          clk, rst, start, score_valid, score_ready;
   logic [SW-1:0] score_in, wr_data;
   logic [IW-1:0] i, j;
   logic [AW-1:0] wr_addr;
   logic          wr_en, busy, done;

   writing_index_score #(.N(N), .SCORE_W(SW), .GAP(GAP)) dut (
      .clk(clk), .rst(rst), .start(start),
      .score_in(score_in), .score_valid(score_valid),
      .score_ready(score_ready), .i(i), .j(j),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .busy(busy), .done(done)
   );

   typedef struct packed {
      logic [31:0]   addr;
      logic [SW-1:0] data;
   } wr_t;

   wr_t exp_q[$];
   int  checks = 0, passes = 0;
   int  pass_writes = 0, exp_pass_writes = 0;
   int  done_cnt = 0;
   int  k;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int req);
      checks++;
      if (act == req) passes++;
      else $display("FAIL %s: got %0d want %0d", name, act, req);
   endtask

   initial begin : monitor
      wr_t e;
      bit  prev_done = 0, prev_wr = 0;
      forever begin
         @(negedge clk);
         if (rst) begin
            if (wr_en) begin
               if (exp_q.size() == 0) chk("unexpected_write", 1, 0);
               else begin
                  e = exp_q.pop_front();
                  chk("wr_addr", int'(wr_addr), int'(e.addr));
                  chk("wr_data", int'(wr_data), int'(e.data));
                  pass_writes++;
               end
            end
            if (done) begin
               done_cnt++;
               chk("done_single", int'(prev_done), 0);
               chk("done_after_wr", int'(prev_wr), 1);
               chk("done_busy", int'(busy), 0);
               chk("done_writes", pass_writes, exp_pass_writes);
               chk("done_queue", exp_q.size(), 0);
            end
         end
         prev_done = done;
         prev_wr   = wr_en;
      end
   end

   task automatic chk_zero(input string tag);
      chk({tag, "_wr_en"}, int'(wr_en), 0);
      chk({tag, "_wr_addr"}, int'(wr_addr), 0);
      chk({tag, "_wr_data"}, int'(wr_data), 0);
      chk({tag, "_i"}, int'(i), 0);
      chk({tag, "_j"}, int'(j), 0);
      chk({tag, "_busy"}, int'(busy), 0);
      chk({tag, "_done"}, int'(done), 0);
      chk({tag, "_ready"}, int'(score_ready), 0);
   endtask

   task automatic do_start();
      wr_t e;
      @(posedge clk); #2;
      start = 1'b1;
      pass_writes = 0;
      exp_pass_writes = N * N;
      k = 0;
`ifdef WRITE_INIT_EN
      for (int c = 0; c <= N; c++) begin
         e.addr = c; e.data = SW'(c * GAP); exp_q.push_back(e);
      end
      for (int r = 1; r <= N; r++) begin
         e.addr = r * (N + 1); e.data = SW'(r * GAP); exp_q.push_back(e);
      end
      exp_pass_writes += 2 * N + 1;
`endif
      @(posedge clk); #2;
      start = 1'b0;
      chk("busy_after_start", int'(busy), 1);
`ifdef WRITE_INIT_EN
      chk("ready_init_first", int'(score_ready), 0);
      for (int c = 0; c < 2 * N + 1; c++) begin
         @(negedge clk);
         chk("init_wr_cont", int'(wr_en), 1);
         chk("init_ready_low", int'(score_ready), 0);
      end
      @(posedge clk); #2;
`endif
   endtask

   // Entered at posedge+2 with the block in FILL; returns 1 if aborted.
   task automatic fill(input int pct, input int abort_at, output bit aborted);
      wr_t e;
      int  cyc = 0;
      bit  v;
      aborted = 0;
      while (k < N * N && cyc < 500) begin
         chk("fill_ready", int'(score_ready), 1);
         chk("fill_i", int'(i), k / N);
         chk("fill_j", int'(j), k % N);
         if (k == abort_at) begin
            score_valid = 1'b0;
            rst = 1'b0;
            #1;
            chk_zero("abort");
            exp_q.delete();
            repeat (3) @(posedge clk);
            #2 rst = 1'b1;
            score_valid = 1'b1;
            repeat (5) begin
               @(posedge clk); #2;
               chk("post_abort_wr", int'(wr_en), 0);
               chk("post_abort_busy", int'(busy), 0);
            end
            score_valid = 1'b0;
            aborted = 1;
            return;
         end
         v = ($urandom_range(99) < pct);
         score_valid = v;
         score_in = SW'($urandom);
         if (v) begin
            e.addr = (k % N + 1) + (N + 1) * (k / N + 1);
            e.data = score_in;
            exp_q.push_back(e);
            k++;
         end
         @(posedge clk); #2;
         cyc++;
      end
      chk("fill_budget", int'(k == N * N), 1);
   endtask

   task automatic finish_pass();
      int d0 = done_cnt;
      chk("ready_after_last", int'(score_ready), 0);
      chk("i_hold", int'(i), N - 1);
      chk("j_hold", int'(j), N - 1);
      chk("busy_in_done", int'(busy), 1);
      score_valid = 1'b1;
      start = 1'b1;
      @(posedge clk); #2;
      start = 1'b0;
      chk("busy_low_at_done", int'(busy), 0);
      repeat (4) begin
         @(posedge clk); #2;
         chk("idle_wr", int'(wr_en), 0);
         chk("idle_busy", int'(busy), 0);
      end
      score_valid = 1'b0;
      chk("done_pulses", done_cnt - d0, 1);
   endtask

   initial begin : main
      bit ab;
      rst = 1'b0; start = 1'b0; score_valid = 1'b0; score_in = '0;
      #12;
      chk_zero("reset");
      rst = 1'b1;
      score_valid = 1'b1;
      @(posedge clk); #2;
      chk("idle_valid_ignored", int'(score_ready), 0);
      score_valid = 1'b0;

      do_start();
      fill(60, -1, ab);
      if (!ab) finish_pass();

      do_start();
      fill(70, 7, ab);

      do_start();
      fill(100, -1, ab);
      if (!ab) finish_pass();

      do_start();
      fill(40, -1, ab);
      if (!ab) finish_pass();

      chk("final_queue", exp_q.size(), 0);
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: timeout reached, required completion");
      $display("%0d/%0d checks passed", passes, checks + 1);
      $fatal(1, "timeout");
   end

endmodule
